decode_execute_skid_stage: RTL and testbench

//  Parametrised ID/EX pipeline register and successor to the fixed-width decode/execute latch.

---
 rtl/pipe_pkg.sv | 15 +
 rtl/pipe_payload_reg.sv | 20 ++
 rtl/decode_execute_skid_stage.sv | 139 +++++++++++++
 tb/tb_decode_execute_skid_stage.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and default widths for the decode/execute skid stage
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_e;

    localparam int PC_W       = 16;
    localparam int DATA_W     = 32;
    localparam int ALU_CTRL_W = 6;
    localparam int REG_ADDR_W = 5;

endpackage

// File: rtl/pipe_payload_reg.sv
// rtl/pipe_payload_reg.sv - load-enabled payload register with asynchronous clear
module pipe_payload_reg #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/decode_execute_skid_stage.sv
// rtl/decode_execute_skid_stage.sv - ID/EX register with valid/ready handshake, 2-entry skid and flush
module decode_execute_skid_stage
    import pipe_pkg::*;
#(
    parameter int PC_W       = pipe_pkg::PC_W,
    parameter int DATA_W     = pipe_pkg::DATA_W,
    parameter int ALU_CTRL_W = pipe_pkg::ALU_CTRL_W,
    parameter int REG_ADDR_W = pipe_pkg::REG_ADDR_W,
    parameter int CNT_W      = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  stall,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ALU_CTRL_W-1:0] in_alu_ctrl,
    input  logic                  in_next_pc_sel,
    input  logic [PC_W-1:0]       in_target_pc,
    input  logic [PC_W-1:0]       in_pc,
    input  logic                  in_op_b_sel,
    input  logic                  in_mem_wen,
    input  logic                  in_reg_wen,
    input  logic [DATA_W-1:0]     in_rs1_data,
    input  logic [DATA_W-1:0]     in_rs2_data,
    input  logic [DATA_W-1:0]     in_imm,
    input  logic [REG_ADDR_W-1:0] in_wb_reg,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ALU_CTRL_W-1:0] out_alu_ctrl,
    output logic                  out_next_pc_sel,
    output logic [PC_W-1:0]       out_target_pc,
    output logic [PC_W-1:0]       out_pc,
    output logic                  out_op_b_sel,
    output logic                  out_mem_wen,
    output logic                  out_reg_wen,
    output logic [DATA_W-1:0]     out_rs1_data,
    output logic [DATA_W-1:0]     out_rs2_data,
    output logic [DATA_W-1:0]     out_imm,
    output logic [REG_ADDR_W-1:0] out_wb_reg,
    output logic [CNT_W-1:0]      bubble_cnt
);

    localparam int PAY_W = ALU_CTRL_W + 2 * PC_W + 4 + 3 * DATA_W + REG_ADDR_W;

    pipe_state_e      state_q, state_d;
    logic             in_fire, out_fire;
    logic             out_load, skid_load, out_from_skid;
    logic [PAY_W-1:0] in_pay, skid_pay, out_pay, out_d;
    logic             next_pc_sel_q, mem_wen_q, reg_wen_q;

    // in_ready depends only on registered state, never on out_ready
    assign in_ready  = (state_q != ST_TWO);
    assign out_valid = (state_q != ST_EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready & ~stall;

    assign in_pay = {in_alu_ctrl, in_next_pc_sel, in_target_pc, in_pc, in_op_b_sel,
                     in_mem_wen, in_reg_wen, in_rs1_data, in_rs2_data, in_imm, in_wb_reg};
    assign out_d  = out_from_skid ? skid_pay : in_pay;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        out_load      = 1'b0;
        skid_load     = 1'b0;
        out_from_skid = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d  = ST_ONE;
                    out_load = 1'b1;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    out_load = 1'b1;
                end else if (in_fire) begin
                    state_d   = ST_TWO;
                    skid_load = 1'b1;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_fire) begin
                    state_d       = ST_ONE;
                    out_load      = 1'b1;
                    out_from_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Payload may still load during a flush; the emptied state masks it
        if (flush) begin
            state_d = ST_EMPTY;
        end
    end

    pipe_payload_reg #(.W(PAY_W)) u_out_entry (
        .clock (clock),
        .reset (reset),
        .load  (out_load),
        .d     (out_d),
        .q     (out_pay)
    );

    pipe_payload_reg #(.W(PAY_W)) u_skid_entry (
        .clock (clock),
        .reset (reset),
        .load  (skid_load),
        .d     (in_pay),
        .q     (skid_pay)
    );

    assign {out_alu_ctrl, next_pc_sel_q, out_target_pc, out_pc, out_op_b_sel,
            mem_wen_q, reg_wen_q, out_rs1_data, out_rs2_data, out_imm, out_wb_reg} = out_pay;

    // Side-effecting controls are masked so an empty slot is a true bubble
    assign out_mem_wen     = mem_wen_q & out_valid;
    assign out_reg_wen     = reg_wen_q & out_valid;
    assign out_next_pc_sel = next_pc_sel_q & out_valid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bubble_cnt <= '0;
        end else if (!out_valid && !flush && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_decode_execute_skid_stage.sv
// tb/tb_decode_execute_skid_stage.sv - self-checking bench for decode_execute_skid_stage
module tb_decode_execute_skid_stage;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    typedef struct packed {
        logic [5:0]  alu;
        logic        nps;
        logic [15:0] tgt;
        logic [15:0] pc;
        logic        obs;
        logic        mwen;
        logic        rwen;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  wb;
    } op_t;

    typedef struct {
        logic        iv;
        logic        ordy;
        logic        stl;
        logic        fl;
        logic [15:0] pc;
        logic        exp_valid;
        logic        exp_ready;
        logic [15:0] exp_pc;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    logic stall = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    op_t  cur = '0;

    logic             in_ready, out_valid;
    logic [5:0]       out_alu_ctrl;
    logic             out_next_pc_sel, out_op_b_sel, out_mem_wen, out_reg_wen;
    logic [15:0]      out_target_pc, out_pc;
    logic [31:0]      out_rs1_data, out_rs2_data, out_imm;
    logic [4:0]       out_wb_reg;
    logic [CNT_W-1:0] bubble_cnt;

    int  checks = 0;
    int  errors = 0;
    op_t model_q[$];
    int  model_cnt = 0;
    vec_t vecs[$];

    always #5 clock = ~clock;

    decode_execute_skid_stage #(.CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_ctrl(cur.alu), .in_next_pc_sel(cur.nps), .in_target_pc(cur.tgt),
        .in_pc(cur.pc), .in_op_b_sel(cur.obs), .in_mem_wen(cur.mwen), .in_reg_wen(cur.rwen),
        .in_rs1_data(cur.rs1), .in_rs2_data(cur.rs2), .in_imm(cur.imm), .in_wb_reg(cur.wb),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_ctrl(out_alu_ctrl), .out_next_pc_sel(out_next_pc_sel),
        .out_target_pc(out_target_pc), .out_pc(out_pc), .out_op_b_sel(out_op_b_sel),
        .out_mem_wen(out_mem_wen), .out_reg_wen(out_reg_wen),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_imm(out_imm),
        .out_wb_reg(out_wb_reg), .bubble_cnt(bubble_cnt)
    );

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic op_t mk_op(input logic [15:0] pc, input logic wens);
        op_t o;
        o.alu  = 6'($urandom);
        o.nps  = wens ? 1'b1 : 1'($urandom);
        o.tgt  = 16'($urandom);
        o.pc   = pc;
        o.obs  = 1'($urandom);
        o.mwen = wens ? 1'b1 : 1'($urandom);
        o.rwen = wens ? 1'b1 : 1'($urandom);
        o.rs1  = wens ? 32'hDEADBEEF : $urandom;
        o.rs2  = $urandom;
        o.imm  = $urandom;
        o.wb   = 5'($urandom);
        return o;
    endfunction

    task automatic compare_model();
        op_t dut_op;
        logic v;
        v = (model_q.size() > 0);
        chk("out_valid", 160'(out_valid), 160'(v));
        chk("in_ready", 160'(in_ready), 160'(model_q.size() < 2));
        chk("bubble_cnt", 160'(bubble_cnt), 160'(model_cnt));
        if (v) begin
            dut_op = {out_alu_ctrl, out_next_pc_sel, out_target_pc, out_pc, out_op_b_sel,
                      out_mem_wen, out_reg_wen, out_rs1_data, out_rs2_data, out_imm, out_wb_reg};
            chk("payload", 160'(dut_op), 160'(model_q[0]));
        end else begin
            chk("gated_wen", 160'({out_mem_wen, out_reg_wen, out_next_pc_sel}), 160'(0));
        end
    endtask

    // One clock: predict fires from the pre-edge model, advance the queue, then compare
    task automatic tick();
        logic ifire, ofire, was_empty;
        was_empty = (model_q.size() == 0);
        ifire = in_valid && (model_q.size() < 2);
        ofire = !was_empty && out_ready && !stall;
        @(posedge clock);
        if (was_empty && !flush && model_cnt < CNT_MAX) model_cnt++;
        if (flush) begin
            model_q.delete();
        end else begin
            if (ofire) void'(model_q.pop_front());
            if (ifire) model_q.push_back(cur);
        end
        #1;
        compare_model();
    endtask

    task automatic add(input logic iv, input logic ordy, input logic stl, input logic fl,
                       input logic [15:0] pc, input logic ev, input logic er, input logic [15:0] epc);
        vec_t t;
        t.iv = iv; t.ordy = ordy; t.stl = stl; t.fl = fl; t.pc = pc;
        t.exp_valid = ev; t.exp_ready = er; t.exp_pc = epc;
        vecs.push_back(t);
    endtask

    initial begin
        // streaming
        add(1, 1, 0, 0, 16'h0010, 1, 1, 16'h0010);
        add(1, 1, 0, 0, 16'h0014, 1, 1, 16'h0014);
        add(1, 1, 0, 0, 16'h0018, 1, 1, 16'h0018);
        add(0, 1, 0, 0, 16'h0000, 0, 1, 16'h0000);
        // back-pressure, third push ignored while full
        add(1, 0, 0, 0, 16'h0020, 1, 1, 16'h0020);
        add(1, 0, 0, 0, 16'h0024, 1, 0, 16'h0020);
        add(1, 0, 0, 0, 16'h0028, 1, 0, 16'h0020);
        add(0, 1, 0, 0, 16'h0000, 1, 1, 16'h0024);
        add(0, 1, 0, 0, 16'h0000, 0, 1, 16'h0000);
        // flush from TWO and flush overriding an in_fire from ONE
        add(1, 0, 0, 0, 16'h0030, 1, 1, 16'h0030);
        add(1, 0, 0, 0, 16'h0034, 1, 0, 16'h0030);
        add(1, 0, 0, 1, 16'h0040, 0, 1, 16'h0000);
        add(1, 0, 0, 0, 16'h0044, 1, 1, 16'h0044);
        add(1, 0, 0, 1, 16'h0048, 0, 1, 16'h0000);
        add(0, 1, 0, 0, 16'h0000, 0, 1, 16'h0000);
        // stall holds output, then skid fills under stall
        add(1, 1, 1, 0, 16'h0050, 1, 1, 16'h0050);
        add(0, 1, 1, 0, 16'h0000, 1, 1, 16'h0050);
        add(0, 1, 1, 0, 16'h0000, 1, 1, 16'h0050);
        add(0, 1, 0, 0, 16'h0000, 0, 1, 16'h0000);
        add(1, 1, 1, 0, 16'h0060, 1, 1, 16'h0060);
        add(1, 1, 1, 0, 16'h0064, 1, 0, 16'h0060);
        add(0, 1, 0, 0, 16'h0000, 1, 1, 16'h0064);
        add(0, 1, 0, 0, 16'h0000, 0, 1, 16'h0000);

        // reset state
        @(posedge clock);
        @(posedge clock);
        #1;
        chk("rst_out_valid", 160'(out_valid), 160'(0));
        chk("rst_in_ready", 160'(in_ready), 160'(1));
        chk("rst_bubble", 160'(bubble_cnt), 160'(0));
        reset = 1'b0;

        foreach (vecs[i]) begin
            in_valid  = vecs[i].iv;
            out_ready = vecs[i].ordy;
            stall     = vecs[i].stl;
            flush     = vecs[i].fl;
            cur       = mk_op(vecs[i].pc, 1'b1);
            tick();
            chk($sformatf("vec%0d_valid", i), 160'(out_valid), 160'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_ready", i), 160'(in_ready), 160'(vecs[i].exp_ready));
            chk($sformatf("vec%0d_mem_wen", i), 160'(out_mem_wen), 160'(vecs[i].exp_valid));
            if (vecs[i].exp_valid)
                chk($sformatf("vec%0d_pc", i), 160'(out_pc), 160'(vecs[i].exp_pc));
        end
        stall = 1'b0;
        flush = 1'b0;

        // randomized traffic against the queue model
        for (int n = 0; n < 400; n++) begin
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            stall     = ($urandom_range(0, 5) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            cur       = mk_op(16'($urandom), 1'b0);
            tick();
        end
        flush = 1'b0;
        stall = 1'b0;

        // asynchronous reset with two ops held
        in_valid  = 1'b1;
        out_ready = 1'b0;
        cur = mk_op(16'h0070, 1'b1);
        tick();
        cur = mk_op(16'h0074, 1'b1);
        tick();
        chk("pre_rst_full", 160'(in_ready), 160'(0));
        in_valid = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        chk("arst_out_valid", 160'(out_valid), 160'(0));
        chk("arst_in_ready", 160'(in_ready), 160'(1));
        chk("arst_reg_wen", 160'(out_reg_wen), 160'(0));
        chk("arst_bubble", 160'(bubble_cnt), 160'(0));
        chk("arst_pc", 160'(out_pc), 160'(0));
        chk("arst_rs1", 160'(out_rs1_data), 160'(0));
        model_q.delete();
        model_cnt = 0;
        @(posedge clock);
        #1;
        reset = 1'b0;

        // bubble counter saturation
        for (int n = 0; n < 20; n++) tick();
        chk("bubble_sat", 160'(bubble_cnt), 160'(CNT_MAX));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
